// File: rtl/dcc_bit_if.sv
// -----------------------------------------------------------------------------
// dcc_bit_if
// Connects a raw DCC track waveform to the bit decoder and carries the decoded
// bit stream back out.
//   dcc_in       : raw DCC waveform, asynchronous to the decoder clock
//   bit_out      : decoded bit value, meaningful while bit_valid is high
//   bit_valid    : one-cycle strobe, a new bit has been decoded
//   bit_error    : one-cycle strobe, framing or timing error
//   preamble_det : level, high while the run of "1" bits reaches the preamble length
// The master modport drives the line (track model or pin wrapper); the slave
// modport is the decoder.
// -----------------------------------------------------------------------------
interface dcc_bit_if;
    logic dcc_in;
    logic bit_out;
    logic bit_valid;
    logic bit_error;
    logic preamble_det;

    modport master (
        output dcc_in,
        input  bit_out,
        input  bit_valid,
        input  bit_error,
        input  preamble_det
    );

    modport slave (
        input  dcc_in,
        output bit_out,
        output bit_valid,
        output bit_error,
        output preamble_det
    );
endinterface

// File: rtl/dcc_bit_decoder.sv
// -----------------------------------------------------------------------------
// dcc_bit_decoder
// Receive side of the DCC bit layer. Oversamples the track waveform on dcc_clk,
// measures every half-period in clock cycles, classifies halves as "1" or "0",
// pairs a low half with the following high half into a bit, and strobes the
// decoded bit out. Framing and timing errors are strobed on bit_error, and a
// run of consecutive "1" bits raises preamble_det.
// Ports:
//   dcc_clk : sampling clock
//   reset   : asynchronous, active-high reset
//   bus     : dcc_bit_if slave (dcc_in in; bit_out, bit_valid, bit_error,
//             preamble_det out; all outputs registered)
// -----------------------------------------------------------------------------
module dcc_bit_decoder #(
    parameter int CNT_W        = 8,
    parameter int ONE_MIN      = 6,
    parameter int ONE_MAX      = 10,
    parameter int ZERO_MIN     = 13,
    parameter int ZERO_MAX     = 20,
    parameter int TIMEOUT      = 64,
    parameter int PREAMBLE_MIN = 10
) (
    input  logic     dcc_clk,
    input  logic     reset,
    dcc_bit_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE_MIN_C  = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] ONE_MAX_C  = CNT_W'(ONE_MAX);
    localparam logic [CNT_W-1:0] ZERO_MIN_C = CNT_W'(ZERO_MIN);
    localparam logic [CNT_W-1:0] ZERO_MAX_C = CNT_W'(ZERO_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [3:0]       RUN_MAX    = 4'hF;
    localparam logic [3:0]       PRE_MIN_C  = 4'(PREAMBLE_MIN);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        LOW_HALF  = 2'd1,
        HIGH_HALF = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HC_BAD  = 2'd0,
        HC_ONE  = 2'd1,
        HC_ZERO = 2'd2
    } half_class_t;

    // Synchronizer and edge detect
    logic s1, s2, s3;
    logic edge_det, rise, fall;

    // Half-period measurement
    logic [CNT_W-1:0] half_cnt;
    half_class_t      half_class;

    // FSM and bit assembly
    state_t     state, state_nxt;
    logic       stored_one, stored_one_nxt;
    logic [3:0] run_cnt, run_nxt;

    // Registered outputs
    logic bit_out_q,   bit_out_nxt;
    logic bit_valid_q, bit_valid_nxt;
    logic bit_error_q, bit_error_nxt;
    logic preamble_q,  preamble_nxt;

    // s1/s2 form the two-flop synchronizer; s3 is the previous synchronized
    // sample, so an edge is seen exactly once, in the cycle s2 changes.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its sources, independent of statement order.
    always_ff @(posedge dcc_clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.dcc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 ^ s3;
    assign rise     = edge_det & s2;
    assign fall     = edge_det & ~s2;

    // Counter reads as the distance to the previous edge when the next edge is
    // detected. It saturates so a dead line never wraps into a valid length.
    always_ff @(posedge dcc_clk or posedge reset) begin
        if (reset) begin
            half_cnt <= '0;
        end else if (edge_det) begin
            half_cnt <= CNT_ONE;
        end else if (half_cnt != CNT_MAX) begin
            half_cnt <= half_cnt + CNT_ONE;
        end
    end

    always_comb begin
        if (half_cnt >= ONE_MIN_C && half_cnt <= ONE_MAX_C) begin
            half_class = HC_ONE;
        end else if (half_cnt >= ZERO_MIN_C && half_cnt <= ZERO_MAX_C) begin
            half_class = HC_ZERO;
        end else begin
            half_class = HC_BAD;
        end
    end

    always_ff @(posedge dcc_clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            stored_one  <= 1'b0;
            run_cnt     <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_error_q <= 1'b0;
            preamble_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            stored_one  <= stored_one_nxt;
            run_cnt     <= run_nxt;
            bit_out_q   <= bit_out_nxt;
            bit_valid_q <= bit_valid_nxt;
            bit_error_q <= bit_error_nxt;
            preamble_q  <= preamble_nxt;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        stored_one_nxt = stored_one;
        run_nxt        = run_cnt;
        bit_out_nxt    = bit_out_q;
        bit_valid_nxt  = 1'b0;
        bit_error_nxt  = 1'b0;
        preamble_nxt   = preamble_q;

        case (state)
            HUNT: begin
                // Every bit starts on a falling edge; a rise here is noise
                // or the line settling, and there is no timeout while hunting.
                if (fall) begin
                    state_nxt = LOW_HALF;
                end
            end

            LOW_HALF: begin
                if (rise) begin
                    if (half_class == HC_BAD) begin
                        bit_error_nxt = 1'b1;
                        state_nxt     = HUNT;
                    end else begin
                        stored_one_nxt = (half_class == HC_ONE);
                        state_nxt      = HIGH_HALF;
                    end
                end else if (half_cnt == TIMEOUT_C) begin
                    bit_error_nxt = 1'b1;
                    state_nxt     = HUNT;
                end
            end

            HIGH_HALF: begin
                if (fall) begin
                    // This fall closes the current bit and opens the next one,
                    // so the FSM stays framed even when the bit is rejected.
                    state_nxt = LOW_HALF;
                    if (half_class != HC_BAD &&
                        (half_class == HC_ONE) == stored_one) begin
                        bit_valid_nxt = 1'b1;
                        bit_out_nxt   = stored_one;
                    end else begin
                        bit_error_nxt = 1'b1;
                    end
                end else if (half_cnt == TIMEOUT_C) begin
                    bit_error_nxt = 1'b1;
                    state_nxt     = HUNT;
                end
            end

            default: begin
                state_nxt = HUNT;
            end
        endcase

        // Run length and preamble flag change only together with a strobe.
        if (bit_valid_nxt && bit_out_nxt) begin
            if (run_cnt != RUN_MAX) begin
                run_nxt = run_cnt + 4'd1;
            end
        end else if (bit_valid_nxt || bit_error_nxt) begin
            run_nxt = '0;
        end

        if (bit_valid_nxt || bit_error_nxt) begin
            preamble_nxt = (run_nxt >= PRE_MIN_C);
        end
    end

    assign bus.bit_out      = bit_out_q;
    assign bus.bit_valid    = bit_valid_q;
    assign bus.bit_error    = bit_error_q;
    assign bus.preamble_det = preamble_q;

endmodule

// File: tb/tb_dcc_bit_decoder.sv
// -----------------------------------------------------------------------------
// tb_dcc_bit_decoder
// Directed bench for dcc_bit_decoder. The line is driven on the falling clock
// edge, so a level held for n calls of the hold task is a half of n cycles.
// A monitor tallies strobes on the falling edge; the main sequence compares
// deltas of those tallies against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_dcc_bit_decoder;

    logic dcc_clk = 1'b0;
    logic reset   = 1'b1;

    dcc_bit_if dif ();

    dcc_bit_decoder dut (
        .dcc_clk (dcc_clk),
        .reset   (reset),
        .bus     (dif)
    );

    always #5 dcc_clk = ~dcc_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Strobe tallies, written only by the monitor.
    int   tot_valid   = 0;
    int   tot_err     = 0;
    int   tot_overlap = 0;
    logic last_bit    = 1'b0;
    logic pre_at_stb  = 1'b0;

    always @(negedge dcc_clk) begin
        if (dif.bit_valid) begin
            tot_valid <= tot_valid + 1;
            last_bit  <= dif.bit_out;
        end
        if (dif.bit_error) begin
            tot_err <= tot_err + 1;
        end
        if (dif.bit_valid || dif.bit_error) begin
            pre_at_stb <= dif.preamble_det;
        end
        if (dif.bit_valid && dif.bit_error) begin
            tot_overlap <= tot_overlap + 1;
        end
    end

    typedef struct {
        int lo;
        int hi;
        int exp_valid;
        int exp_bit;
        int exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        dif.dcc_in = lvl;
        repeat (n) @(negedge dcc_clk);
    endtask

    // Line is left high across reset release, so the resulting rise must be
    // ignored by the hunting FSM.
    task automatic apply_reset();
        dif.dcc_in = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge dcc_clk);
        reset = 1'b0;
    endtask

    int v0, e0;

    initial begin
        vecs[0]  = '{lo: 6,  hi: 6,  exp_valid: 1, exp_bit: 1, exp_err: 0};
        vecs[1]  = '{lo: 10, hi: 10, exp_valid: 1, exp_bit: 1, exp_err: 0};
        vecs[2]  = '{lo: 8,  hi: 8,  exp_valid: 1, exp_bit: 1, exp_err: 0};
        vecs[3]  = '{lo: 13, hi: 13, exp_valid: 1, exp_bit: 0, exp_err: 0};
        vecs[4]  = '{lo: 20, hi: 20, exp_valid: 1, exp_bit: 0, exp_err: 0};
        vecs[5]  = '{lo: 16, hi: 16, exp_valid: 1, exp_bit: 0, exp_err: 0};
        vecs[6]  = '{lo: 5,  hi: 8,  exp_valid: 0, exp_bit: 0, exp_err: 1};
        vecs[7]  = '{lo: 11, hi: 8,  exp_valid: 0, exp_bit: 0, exp_err: 1};
        vecs[8]  = '{lo: 12, hi: 8,  exp_valid: 0, exp_bit: 0, exp_err: 1};
        vecs[9]  = '{lo: 21, hi: 8,  exp_valid: 0, exp_bit: 0, exp_err: 1};
        vecs[10] = '{lo: 8,  hi: 21, exp_valid: 0, exp_bit: 0, exp_err: 1};
        vecs[11] = '{lo: 8,  hi: 5,  exp_valid: 0, exp_bit: 0, exp_err: 1};
        vecs[12] = '{lo: 8,  hi: 16, exp_valid: 0, exp_bit: 0, exp_err: 1};
        vecs[13] = '{lo: 16, hi: 8,  exp_valid: 0, exp_bit: 0, exp_err: 1};

        dif.dcc_in = 1'b1;
        @(negedge dcc_clk);

        // ---- Reset state ----
        check("rst_bit_out",   int'(dif.bit_out), 0);
        check("rst_bit_valid", int'(dif.bit_valid), 0);
        check("rst_bit_error", int'(dif.bit_error), 0);
        check("rst_preamble",  int'(dif.preamble_det), 0);

        // ---- Preamble of ten 8/8 ones, then a 16/16 zero ----
        apply_reset();
        hold(1'b1, 10);
        v0 = tot_valid;
        e0 = tot_err;
        for (int i = 0; i < 10; i++) begin
            hold(1'b0, 5);
            check($sformatf("pre_valid_cnt_%0d", i), tot_valid - v0, i);
            if (i == 9) begin
                check("pre_det_before_10th", int'(dif.preamble_det), 0);
            end
            hold(1'b0, 3);
            hold(1'b1, 8);
        end
        hold(1'b0, 5);
        check("pre_valid_cnt_10", tot_valid - v0, 10);
        check("pre_last_bit_1",   int'(last_bit), 1);
        check("pre_det_level",    int'(dif.preamble_det), 1);
        check("pre_det_with_10th", int'(pre_at_stb), 1);
        hold(1'b0, 11);
        hold(1'b1, 16);
        hold(1'b0, 5);
        check("zero_valid_cnt",   tot_valid - v0, 11);
        check("zero_bit_out",     int'(last_bit), 0);
        check("zero_pre_level",   int'(dif.preamble_det), 0);
        check("zero_pre_at_stb",  int'(pre_at_stb), 0);
        check("pre_no_errors",    tot_err - e0, 0);

        // ---- Boundary table: one bit per vector from a clean reset ----
        foreach (vecs[i]) begin
            apply_reset();
            hold(1'b1, 4);
            v0 = tot_valid;
            e0 = tot_err;
            hold(1'b0, vecs[i].lo);
            hold(1'b1, vecs[i].hi);
            hold(1'b0, 6);
            check($sformatf("vec%0d_%0d_%0d_valid", i, vecs[i].lo, vecs[i].hi),
                  tot_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_%0d_%0d_error", i, vecs[i].lo, vecs[i].hi),
                  tot_err - e0, vecs[i].exp_err);
            if (vecs[i].exp_valid != 0) begin
                check($sformatf("vec%0d_bit", i), int'(last_bit), vecs[i].exp_bit);
            end
        end

        // ---- Mismatch after a preamble: error, then resync without HUNT ----
        apply_reset();
        hold(1'b1, 4);
        v0 = tot_valid;
        e0 = tot_err;
        for (int i = 0; i < 11; i++) begin
            hold(1'b0, 8);
            hold(1'b1, 8);
        end
        hold(1'b0, 8);
        check("mm_ones_cnt",    tot_valid - v0, 11);
        check("mm_pre_before",  int'(dif.preamble_det), 1);
        hold(1'b1, 16);
        hold(1'b0, 5);
        check("mm_error_cnt",   tot_err - e0, 1);
        check("mm_no_valid",    tot_valid - v0, 11);
        check("mm_pre_cleared", int'(dif.preamble_det), 0);
        hold(1'b0, 3);
        hold(1'b1, 8);
        hold(1'b0, 5);
        check("mm_resync_cnt",  tot_valid - v0, 12);
        check("mm_resync_bit",  int'(last_bit), 1);
        check("mm_resync_pre",  int'(dif.preamble_det), 0);
        check("mm_error_total", tot_err - e0, 1);

        // ---- Timeout in LOW_HALF, then rise ignored, fall re-arms ----
        apply_reset();
        hold(1'b1, 5);
        v0 = tot_valid;
        e0 = tot_err;
        hold(1'b0, 3);
        hold(1'b0, 60);
        check("to_no_early_error", tot_err - e0, 0);
        hold(1'b0, 20);
        check("to_single_error",   tot_err - e0, 1);
        hold(1'b1, 10);
        check("to_rise_ignored",   tot_err - e0, 1);
        check("to_no_valid",       tot_valid - v0, 0);
        hold(1'b0, 8);
        hold(1'b1, 8);
        hold(1'b0, 5);
        check("to_rearm_valid",    tot_valid - v0, 1);
        check("to_rearm_bit",      int'(last_bit), 1);
        check("to_rearm_no_error", tot_err - e0, 1);

        // ---- Reset mid HIGH_HALF with a run of seven ones ----
        apply_reset();
        hold(1'b1, 4);
        v0 = tot_valid;
        e0 = tot_err;
        for (int i = 0; i < 7; i++) begin
            hold(1'b0, 8);
            hold(1'b1, 8);
        end
        hold(1'b0, 8);
        hold(1'b1, 4);
        check("mr_run7_cnt",    tot_valid - v0, 7);
        check("mr_bit_out_pre", int'(dif.bit_out), 1);
        reset = 1'b1;
        #1;
        check("mr_bit_out",     int'(dif.bit_out), 0);
        check("mr_bit_valid",   int'(dif.bit_valid), 0);
        check("mr_bit_error",   int'(dif.bit_error), 0);
        check("mr_preamble",    int'(dif.preamble_det), 0);
        repeat (2) @(negedge dcc_clk);
        reset = 1'b0;
        hold(1'b1, 4);
        check("mr_no_pulse_err",   tot_err - e0, 0);
        check("mr_no_pulse_valid", tot_valid - v0, 7);
        v0 = tot_valid;
        for (int i = 0; i < 10; i++) begin
            hold(1'b0, 5);
            if (i == 9) begin
                check("mr_nine_cnt", tot_valid - v0, 9);
                check("mr_pre_at_9", int'(dif.preamble_det), 0);
            end
            hold(1'b0, 3);
            hold(1'b1, 8);
        end
        hold(1'b0, 5);
        check("mr_ten_cnt",  tot_valid - v0, 10);
        check("mr_pre_at_10", int'(dif.preamble_det), 1);

        // ---- Long constant line in HUNT: counter saturates, no strobes ----
        apply_reset();
        v0 = tot_valid;
        e0 = tot_err;
        hold(1'b1, 300);
        check("slow_no_valid", tot_valid - v0, 0);
        check("slow_no_error", tot_err - e0, 0);
        check("slow_cnt_sat",  int'(dut.half_cnt), 255);

        check("no_valid_error_overlap", tot_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcc_bit_decoder.md
Name: dcc_bit_decoder

Overview:
- Receive-side counterpart of the DCC bit encoder.
- Oversamples a raw DCC track waveform on dcc_clk and measures each half-period in clock cycles.
- Classifies each half as a "1" half or a "0" half, pairs halves into bits, and emits decoded bits with a one-cycle strobe.
- Also flags framing errors and detects the DCC preamble. It feeds the packet deframer.

Parameters:
CNT_W, 8, width of half-period counter (saturating)
ONE_MIN, 6, minimum accepted "1" half length in cycles
ONE_MAX, 10, maximum accepted "1" half length in cycles
ZERO_MIN, 13, minimum accepted "0" half length in cycles
ZERO_MAX, 20, maximum accepted "0" half length in cycles
TIMEOUT, 64, cycles without an edge before abandoning a bit (must be < 2^CNT_W)
PREAMBLE_MIN, 10, consecutive "1" bits required for preamble_det

Ports:
dcc_clk  input  1  sampling clock
reset  input  1  asynchronous, active-high reset
dcc_in  input  1  raw DCC waveform, asynchronous to dcc_clk
bit_out  output  1  decoded bit value, meaningful when bit_valid=1
bit_valid  output  1  one-cycle strobe, new decoded bit
bit_error  output  1  one-cycle strobe, framing or timing error
preamble_det  output  1  level, high while run of "1" bits >= PREAMBLE_MIN

Behaviour:
- Reset: immediate clear of all state.
  - bit_out=0, bit_valid=0, bit_error=0, preamble_det=0.
  - Synchronizer flops s1/s2/s3=0, half counter=0, ones run count=0, FSM=HUNT.
- Input sync and edge detect:
  - dcc_in passes through s1->s2; s3 holds the previous s2.
  - Edge detected in the cycle where s2!=s3: rise if s2=1, fall if s2=0.
- Half counter:
  - Loads 1 on an edge-detect cycle; otherwise increments, saturating at 2^CNT_W-1.
  - Length L of a completed half = counter value in the edge-detect cycle, i.e. the cycle distance between consecutive edges.
- Classification of L:
  - ONE if ONE_MIN<=L<=ONE_MAX.
  - ZERO if ZERO_MIN<=L<=ZERO_MAX.
  - Otherwise BAD.
  - Bounds are inclusive.
- Bit framing: a bit is a low half followed by a high half, so every bit starts at a falling edge.
- FSM states and transitions:
  - HUNT: fall -> LOW_HALF. Rise is ignored. No timeout in HUNT.
  - LOW_HALF, on rise:
    - class ONE/ZERO -> store class, go to HIGH_HALF.
    - BAD -> bit_error, go to HUNT.
  - HIGH_HALF, on fall:
    - class equals stored class -> bit_valid=1, bit_out=class (1 for ONE), go to LOW_HALF (this fall starts the next bit).
    - BAD or mismatch -> bit_error, no bit_valid, go to LOW_HALF (resynchronise on this fall).
  - LOW_HALF or HIGH_HALF with counter reaching TIMEOUT and no edge:
    - Single bit_error pulse in the cycle counter==TIMEOUT, go to HUNT.
- Output timing:
  - bit_valid, bit_out and bit_error are registered; they assert in the cycle after the edge-detect cycle, i.e. after the 3rd dcc_clk rising edge following the pin transition.
  - bit_valid and bit_error are never high together; each lasts exactly one cycle.
  - bit_out holds its value between strobes.
- Preamble run count:
  - Saturating at 15; updated in the same cycle as bit_valid or bit_error.
  - +1 on valid 1. Cleared on valid 0, on any bit_error, and on timeout.
  - preamble_det = (run >= PREAMBLE_MIN), registered and updated in the same cycle as the strobe.
  - It drops in the cycle bit_valid shows a 0 bit.
- Reset mid-bit: outputs clear asynchronously. After release, the FSM waits in HUNT for a fresh falling edge. No pulse is generated by the reset itself.
- Line high at reset release: s2 goes 1 -> rise detected, ignored in HUNT.

Test Plan:
1. After reset, dcc_in high, then 10 bits of 8 cycles low / 8 high -> 10 bit_valid pulses with bit_out=1, one per falling edge, the first at the 2nd falling edge. preamble_det rises with the 10th pulse. A following 16/16 bit -> bit_valid with bit_out=0, preamble_det=0 in the same cycle.
2. Boundaries:
   - Halves 6/6 and 10/10 -> decoded 1.
   - 13/13 and 20/20 -> decoded 0.
   - Low half 5, 11 or 12 -> bit_error on the rise, FSM in HUNT.
   - High half 21 after an accepted low half -> bit_error on the fall.
3. Mismatch: low 8 / high 16 -> bit_error at the closing fall, no bit_valid. The next 8/8 bit is decoded as 1 without an intervening HUNT. preamble run is cleared.
4. Timeout: stop toggling 3 cycles into LOW_HALF -> exactly one bit_error when the counter reaches 64. A subsequent rise is ignored, and the next fall re-arms the FSM.
5. Reset asserted mid HIGH_HALF with run=7 -> all outputs 0 immediately. After release, 8/8 bits decode, and preamble_det requires 10 new 1 bits.
6. Glitch-free slow line: dcc_in constant for 300 cycles in HUNT -> no strobes, and the counter saturates at 255 without wrapping.
